// File: rtl/normalizer_pkg.sv
// Shared types and helpers for the multi-channel frame normalizer.
package normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    RECIP = 2'd2,
    OUT   = 2'd3
  } norm_state_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/norm_recip_div.sv
// Sequential restoring divider: quotient = floor(2^dividend_exp / divisor), one bit per cycle.
module norm_recip_div
  import normalizer_pkg::*;
#(
  parameter int unsigned W_D = 20,
  parameter int unsigned W_Q = 29,
  parameter int unsigned W_E = $clog2(W_Q)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W_E-1:0] dividend_exp,
  input  logic [W_D-1:0] divisor,
  output logic           done,
  output logic [W_Q-1:0] quotient
);

  localparam int unsigned W_C = $clog2(W_Q + 1);

  logic [W_D-1:0] r_rem;
  logic [W_Q-1:0] r_dvd;
  logic [W_D-1:0] r_div;
  logic [W_Q-1:0] r_q;
  logic [W_C-1:0] r_cnt;
  logic           r_run;
  logic           r_done;

  logic [W_Q-1:0] w_dividend;
  logic [W_D-1:0] w_rem_in;
  logic [W_D-1:0] w_d;
  logic [W_D:0]   w_shift;
  logic           w_bit;
  logic           w_ge;
  logic [W_D-1:0] w_rem_nxt;

  // The start cycle performs the first step directly from the ports.
  always_comb begin
    w_dividend = W_Q'(1) << dividend_exp;
    w_rem_in   = start ? '0 : r_rem;
    w_bit      = start ? w_dividend[W_Q-1] : r_dvd[W_Q-1];
    w_d        = start ? divisor : r_div;
    w_shift    = {w_rem_in, w_bit};
    w_ge       = (w_shift >= {1'b0, w_d});
    w_rem_nxt  = w_ge ? W_D'(w_shift - {1'b0, w_d}) : w_shift[W_D-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_div  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem <= w_rem_nxt;
        r_dvd <= w_dividend << 1;
        r_div <= divisor;
        r_q   <= W_Q'(w_ge);
        r_cnt <= W_C'(1);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_rem_nxt;
        r_dvd <= r_dvd << 1;
        r_q   <= {r_q[W_Q-2:0], w_ge};
        r_cnt <= r_cnt + W_C'(1);
        if (r_cnt == W_C'(W_Q - 1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_q;

endmodule

// File: rtl/normalizer_mc.sv
// Multi-channel frame normalizer: sums a frame, divides once, streams elem*2^FRAC/total.
// Build option NORMALIZER_ROUND_EN selects round-half-away-from-zero instead of truncation.
module normalizer_mc
  import normalizer_pkg::*;
#(
  parameter int unsigned BW_PSUM = 16,
  parameter int unsigned COL     = 8,
  parameter int unsigned N_CH    = 2,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned W_OUT   = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [N_CH-1:0][COL-1:0][BW_PSUM-1:0]  s_psum,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [N_CH-1:0][W_OUT-1:0]             m_data,
  output logic                                   m_last,
  output logic                                   m_zero,
  output logic                                   busy
);

  localparam int unsigned W_SUM = BW_PSUM + $clog2(COL * N_CH);
  localparam int unsigned W_R   = FRAC + W_SUM + 1;
  localparam int unsigned W_CNT = $clog2(COL);
  localparam int unsigned W_EXP = $clog2(W_R);
  localparam int unsigned W_P   = BW_PSUM + W_R;
  localparam int unsigned W_M   = W_P - W_SUM;
`ifdef NORMALIZER_ROUND_EN
  localparam logic [W_P-1:0] RND = W_P'(1) << (W_SUM - 1);
`else
  localparam logic [W_P-1:0] RND = '0;
`endif

  norm_state_t                           r_state;
  logic [N_CH-1:0][COL-1:0][BW_PSUM-1:0] r_rot;
  logic [N_CH-1:0][COL-1:0][BW_PSUM-1:0] w_rot;
  logic signed [W_SUM-1:0]               r_sum;
  logic signed [W_SUM-1:0]               w_add;
  logic signed [W_SUM-1:0]               w_sum_nxt;
  logic [W_SUM-1:0]                      w_abs_sum;
  logic [W_CNT-1:0]                      r_cnt;
  logic                                  r_neg;
  logic                                  r_valid;
  logic                                  r_last;
  logic                                  r_zero;
  logic [N_CH-1:0][W_OUT-1:0]            r_data;
  logic [N_CH-1:0][W_OUT-1:0]            w_beat;
  logic                                  w_sum_last;
  logic                                  w_div_start;
  logic                                  w_div_done;
  logic [W_R-1:0]                        w_recip;

  // Magnitude scaling by the reciprocal, sign restore, then clamp to W_OUT.
  function automatic logic [W_OUT-1:0] f_scale(input logic [BW_PSUM-1:0] e,
                                               input logic [W_R-1:0]     r,
                                               input logic               neg_sum);
    logic [BW_PSUM-1:0] mag_e;
    logic [W_P-1:0]     prod;
    logic [W_M-1:0]     mag;
    logic signed [63:0] val;
    mag_e = e[BW_PSUM-1] ? -e : e;
    prod  = W_P'(mag_e) * W_P'(r) + RND;
    mag   = W_M'(prod >> W_SUM);
    val   = $signed(64'(mag));
    if (e[BW_PSUM-1] ^ neg_sum) val = -val;
    return W_OUT'(sat_signed(val, W_OUT));
  endfunction

  always_comb begin
    w_add  = '0;
    w_rot  = '0;
    w_beat = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_add     = w_add + W_SUM'($signed(r_rot[c][0]));
      w_rot[c]  = {r_rot[c][0], r_rot[c][COL-1:1]};
      w_beat[c] = f_scale(r_rot[c][0], w_recip, r_neg);
    end
    w_sum_nxt   = r_sum + w_add;
    w_abs_sum   = w_sum_nxt[W_SUM-1] ? $unsigned(-w_sum_nxt) : $unsigned(w_sum_nxt);
    w_sum_last  = (r_state == SUM) && (r_cnt == W_CNT'(COL - 1));
    w_div_start = w_sum_last && (w_sum_nxt != '0);
  end

  norm_recip_div #(
    .W_D (W_SUM),
    .W_Q (W_R),
    .W_E (W_EXP)
  ) u_div (
    .clk          (clk),
    .reset        (reset),
    .start        (w_div_start),
    .dividend_exp (W_EXP'(FRAC + W_SUM)),
    .divisor      (w_abs_sum),
    .done         (w_div_done),
    .quotient     (w_recip)
  );

  // Element k sits at rotate position 0; each accepted beat pre-computes the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rot   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_zero  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_rot   <= s_psum;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_state <= SUM;
          end
        end
        SUM: begin
          r_sum <= w_sum_nxt;
          r_rot <= w_rot;
          r_cnt <= r_cnt + W_CNT'(1);
          if (w_sum_last) begin
            r_cnt <= '0;
            r_neg <= w_sum_nxt[W_SUM-1];
            if (w_div_start) begin
              r_state <= RECIP;
            end else begin
              r_state <= OUT;
              r_valid <= 1'b1;
              r_zero  <= 1'b1;
              r_last  <= 1'b0;
              r_data  <= '0;
            end
          end
        end
        RECIP: begin
          if (w_div_done) begin
            r_data  <= w_beat;
            r_rot   <= w_rot;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_zero  <= 1'b0;
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt  <= r_cnt + W_CNT'(1);
              r_last <= (r_cnt == W_CNT'(COL - 2));
              r_data <= r_zero ? '0 : w_beat;
              r_rot  <= w_rot;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_ready = (r_state == IDLE) & ~reset;
  assign busy    = (r_state != IDLE);
  assign m_valid = r_valid;
  assign m_last  = r_last;
  assign m_zero  = r_zero;
  assign m_data  = r_data;

endmodule

// File: doc/normalizer_mc.md
# normalizer_mc

Multi-channel, stream-handshaked frame normalizer, the generalised successor of the two-stream normalizer. It accepts one frame of `N_CH × COL` signed partial sums and forms their signed total. It computes one reciprocal of the total with a shared sequential divider, then emits each element scaled as `elem·2^FRAC/total`, one column per beat under valid/ready backpressure. It sits after the PE-array psum outputs; all channels are already synchronised to `clk` upstream.

## Interface
- `BW_PSUM`, 16, signed psum element width
- `COL`, 8, elements per channel per frame (≥2)
- `N_CH`, 2, channel count (≥1)
- `FRAC`, 8, output fraction bits (scale 2^FRAC)
- `W_OUT`, 16, signed output width
- Derived: `W_SUM = BW_PSUM + $clog2(COL*N_CH)`, `W_R = FRAC + W_SUM + 1`
- `clk` in 1 — clock
- `reset` in 1 — reset, synchronous, active-high
- `s_valid` in 1 — input frame valid
- `s_ready` out 1 — frame accepted when `s_valid && s_ready`
- `s_psum` in `[N_CH][COL][BW_PSUM]` — frame, signed elements
- `m_valid` out 1 — output beat valid
- `m_ready` in 1 — downstream accepts beat
- `m_data` out `[N_CH][W_OUT]` — normalized column k of every channel, signed
- `m_last` out 1 — marks beat COL-1
- `m_zero` out 1 — frame total was zero; valid with every beat of that frame
- `busy` out 1 — state ≠ IDLE

## Operation
- States: IDLE → SUM → RECIP → OUT → IDLE; SUM → OUT directly when the total is 0.
- IDLE: `s_ready`=1. On handshake, latch the frame into per-channel rotate registers, clear `sum`, go to SUM.
- SUM: exactly COL cycles.
  - Each cycle adds element k of all N_CH channels, sign-extended, into `sum` (W_SUM bits, no overflow possible), then rotates by one element.
  - After COL cycles the registers are back in original order.
- RECIP: `norm_recip_div` computes `R = floor(2^(FRAC+W_SUM) / |sum|)`, W_R bits, one quotient bit per cycle (restoring).
  - Capture `neg_sum = sum<0`.
- OUT: beat k (k=0..COL-1) holds, for each channel c:
  - `mag = (|e[c][k]|·R) >> W_SUM`
  - sign = `sign(e)` XOR `neg_sum`
  - then saturate to `[-2^(W_OUT-1), 2^(W_OUT-1)-1]`.
  - Advance k, and rotate, only on `m_valid && m_ready`. `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- Zero total: skip RECIP. Emit COL beats of all-zero `m_data` with `m_zero`=1.
- Results are exact for power-of-two totals, and within 1 LSB of the ideal magnitude otherwise.

## Timing
- Reset values: `s_ready`=0 while `reset` is high; `m_valid`, `m_last`, `m_zero`, `busy`=0; `m_data`=0; state IDLE; count 0.
- `s_ready` is 1 from the first cycle after `reset` deasserts.
- Latency from handshake cycle T to first `m_valid` is T+1+COL+W_R cycles (T+1+COL for a zero total).
- `m_data` is registered. The multiply/sign/saturate stage is computed one cycle ahead of `m_valid`.
- Zero backpressure gives one beat per cycle. `m_last` coincides with beat COL-1.
- `s_ready` returns to 1 in the cycle after the `m_last` handshake. There is no overlap of input and output frames.
- `s_valid` is ignored outside IDLE. `s_psum` is sampled only at handshake.
- `reset` mid-frame aborts in the next cycle: the frame is dropped, no further beats appear, and all outputs return to their reset values.
- `m_ready` held low indefinitely stalls in OUT with no data loss.

## Configuration
- `NORMALIZER_ROUND_EN` defined: adds `2^(W_SUM-1)` before the `>> W_SUM`, giving round-half-away-from-zero on the magnitude.
- Not defined: the magnitude truncates, i.e. rounds toward zero.
- The reciprocal is identical in both cases.

## Structure
- `normalizer_pkg` holds:
  - the `norm_state_t` enum {IDLE, SUM, RECIP, OUT};
  - the `sat_signed` function (value and target width, as used for the W_OUT clamp).
- Derived widths stay as localparams in the module.
- Sub-module `norm_recip_div` is the sequential restoring divider, parameterised by divisor/quotient widths.
  - Ports: `start`, `dividend_exp`, `divisor`, `done`, `quotient`.
  - `done` pulses W_R cycles after `start`.

## Test plan
- COL=8, N_CH=2, FRAC=8, all elements +1 → sum 16, R=2^(8+W_SUM)/16; 8 beats of `m_data`=16 per channel, `m_last` on beat 7, `m_zero`=0.
- Ch0 = {64,0,…,0}, ch1 all 0 → beat0 ch0=256, every other element 0.
- Elements all −2 → sum −32. Every output +16, since the sign of `e` and the sign of `sum` cancel.
- One element +5, one −5, rest 0 → zero total. Skip RECIP; 8 beats of 0 with `m_zero`=1, first beat at T+1+COL.
- Random `m_ready` (50%) on a random frame → `m_data` stable while stalled. Values match the reference model: truncate without `NORMALIZER_ROUND_EN`, and ±1 LSB-correct rounding with it (e.g. total 3, element 1, FRAC=8 → 85 truncated, 85 rounded; element 2 → 170 vs 171).
- `reset` asserted mid-RECIP → next cycle `m_valid`=0 and `busy`=0; first cycle after release `s_ready`=1. A new frame of all-1 values then normalizes correctly.
